// File: rtl/uart_txq_pkg.sv
// uart_txq_pkg
// Shared definitions for the uart transmit queue: drain FSM state encoding,
// data width and default parameter values.
// No ports.

package uart_txq_pkg;

  // Drain FSM states.
  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    STROBE = 2'd1,
    WAIT   = 2'd2
  } txq_state_e;

  localparam int unsigned DATA_W         = 8;
  localparam int unsigned DEPTH_LOG2_DEF = 4;
  localparam int unsigned WR_TIMEOUT_DEF = 64;

endpackage

// File: rtl/uart_txq_fifo.sv
// uart_txq_fifo
// Synchronous byte FIFO with push, pop and flush. Full, empty, level and the
// overflow pulse are registered and reflect the pointer state after each edge.
//
// Ports:
//   clk_i       system clock
//   rst_i       synchronous reset, active-high
//   push_i      store push_dat_i this edge (dropped when full or flushing)
//   push_dat_i  data to store
//   pop_i       advance the read pointer this edge (ignored when empty)
//   flush_i     clear both pointers; overrides a same-cycle push
//   head_o      byte at the read pointer (valid when !empty_o)
//   full_o      FIFO full
//   empty_o     FIFO empty
//   level_o     stored byte count
//   ovf_o       one-cycle pulse after a push was dropped because of full

module uart_txq_fifo
  import uart_txq_pkg::*;
#(
  parameter int unsigned DEPTH_LOG2 = DEPTH_LOG2_DEF
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              push_i,
  input  logic [DATA_W-1:0] push_dat_i,
  input  logic              pop_i,
  input  logic              flush_i,
  output logic [DATA_W-1:0] head_o,
  output logic              full_o,
  output logic              empty_o,
  output logic [DEPTH_LOG2:0] level_o,
  output logic              ovf_o
);

  localparam int unsigned DEPTH = 1 << DEPTH_LOG2;
  localparam int unsigned PTR_W = DEPTH_LOG2 + 1;

  if (DEPTH_LOG2 < 1) begin : g_bad_depth
    $error("uart_txq_fifo: DEPTH_LOG2 must be at least 1");
  end

  logic [DATA_W-1:0] mem_q [DEPTH];

  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [PTR_W-1:0] level_q, level_d;
  logic             full_q, full_d;
  logic             empty_q, empty_d;
  logic             ovf_q, ovf_d;
  logic             push_ok;
  logic             pop_ok;

  always_comb begin
    // Full/empty come from registered state, so a pop in the same cycle
    // never makes room for a push that arrived while full.
    push_ok  = push_i & ~full_q & ~flush_i;
    pop_ok   = pop_i & ~empty_q;
    ovf_d    = push_i & full_q & ~flush_i;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (flush_i) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
    end else begin
      if (push_ok) wr_ptr_d = wr_ptr_q + PTR_W'(1);
      if (pop_ok)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
    end
    level_d = wr_ptr_d - rd_ptr_d;
    empty_d = (wr_ptr_d == rd_ptr_d);
    // Pointers carry one extra wrap bit: full when only that bit differs.
    full_d  = (wr_ptr_d[PTR_W-1] != rd_ptr_d[PTR_W-1]) &&
              (wr_ptr_d[PTR_W-2:0] == rd_ptr_d[PTR_W-2:0]);
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
      full_q   <= 1'b0;
      empty_q  <= 1'b1;
      ovf_q    <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      level_q  <= level_d;
      full_q   <= full_d;
      empty_q  <= empty_d;
      ovf_q    <= ovf_d;
    end
  end

  // Storage needs no reset; the pointers define what is valid.
  always_ff @(posedge clk_i) begin
    if (push_ok) mem_q[wr_ptr_q[DEPTH_LOG2-1:0]] <= push_dat_i;
  end

  assign head_o  = mem_q[rd_ptr_q[DEPTH_LOG2-1:0]];
  assign full_o  = full_q;
  assign empty_o = empty_q;
  assign level_o = level_q;
  assign ovf_o   = ovf_q;

endmodule

// File: rtl/uart_tx_queue.sv
// uart_tx_queue
// Byte queue in front of the uart transmitter. Producers push bytes at system
// clock rate; the drain FSM hands them to the uart one at a time, holding
// tx_wr_o until the uart reports busy, then waiting for busy to drop.
//
// Optional feature, macro UART_TXQ_TIMEOUT_EN: a write that sees no busy for
// WR_TIMEOUT cycles is abandoned, tx_err_o pulses and the FSM returns to IDLE.
// Without the macro STROBE waits indefinitely and tx_err_o is tied 0.
//
// Ports:
//   sys_clk_i   system clock
//   sys_rst_i   synchronous reset, active-high
//   q_wr_i      push strobe, one byte per cycle
//   q_dat_i     push data
//   q_flush_i   discard all queued bytes (in-flight byte still completes)
//   q_full_o    queue full
//   q_empty_o   queue empty
//   q_level_o   stored byte count
//   q_ovf_o     one-cycle pulse: push dropped because queue was full
//   tx_busy_i   uart busy
//   tx_wr_o     uart write strobe
//   tx_dat_o    uart write data, changes only on a pop
//   tx_err_o    one-cycle pulse on write timeout
//
// State table:
//   IDLE   | no byte handed out; pops the head when the queue is not empty
//   STROBE | tx_wr_o high with tx_dat_o stable, waiting for tx_busy_i
//   WAIT   | uart accepted the byte, waiting for tx_busy_i to drop

module uart_tx_queue
  import uart_txq_pkg::*;
#(
  parameter int unsigned DEPTH_LOG2 = DEPTH_LOG2_DEF,
  parameter int unsigned WR_TIMEOUT = WR_TIMEOUT_DEF
) (
  input  logic                sys_clk_i,
  input  logic                sys_rst_i,
  input  logic                q_wr_i,
  input  logic [DATA_W-1:0]   q_dat_i,
  input  logic                q_flush_i,
  output logic                q_full_o,
  output logic                q_empty_o,
  output logic [DEPTH_LOG2:0] q_level_o,
  output logic                q_ovf_o,
  input  logic                tx_busy_i,
  output logic                tx_wr_o,
  output logic [DATA_W-1:0]   tx_dat_o,
  output logic                tx_err_o
);

  if (WR_TIMEOUT < 1) begin : g_bad_timeout
    $error("uart_tx_queue: WR_TIMEOUT must be at least 1");
  end

  txq_state_e        state_q, state_d;
  logic              tx_wr_q, tx_wr_d;
  logic [DATA_W-1:0] tx_dat_q, tx_dat_d;
  logic              pop;
  logic [DATA_W-1:0] fifo_head;
  logic              fifo_empty;

  uart_txq_fifo #(
    .DEPTH_LOG2 (DEPTH_LOG2)
  ) u_fifo (
    .clk_i      (sys_clk_i),
    .rst_i      (sys_rst_i),
    .push_i     (q_wr_i),
    .push_dat_i (q_dat_i),
    .pop_i      (pop),
    .flush_i    (q_flush_i),
    .head_o     (fifo_head),
    .full_o     (q_full_o),
    .empty_o    (fifo_empty),
    .level_o    (q_level_o),
    .ovf_o      (q_ovf_o)
  );

  assign q_empty_o = fifo_empty;

`ifdef UART_TXQ_TIMEOUT_EN
  localparam int unsigned TMO_W = $clog2(WR_TIMEOUT + 1);

  // Down-counter loaded on entry to STROBE; terminal count at zero marks the
  // WR_TIMEOUT-th cycle spent in STROBE without busy.
  logic [TMO_W-1:0] tmo_cnt_q, tmo_cnt_d;
  logic             tx_err_q, tx_err_d;
`endif

  always_comb begin
    state_d  = state_q;
    tx_wr_d  = tx_wr_q;
    tx_dat_d = tx_dat_q;
    pop      = 1'b0;
`ifdef UART_TXQ_TIMEOUT_EN
    tmo_cnt_d = tmo_cnt_q;
    tx_err_d  = 1'b0;
`endif
    unique case (state_q)
      IDLE: begin
        if (!fifo_empty) begin
          pop      = 1'b1;
          tx_dat_d = fifo_head;
          tx_wr_d  = 1'b1;
          state_d  = STROBE;
`ifdef UART_TXQ_TIMEOUT_EN
          tmo_cnt_d = TMO_W'(WR_TIMEOUT - 1);
`endif
        end
      end
      STROBE: begin
        if (tx_busy_i) begin
          tx_wr_d = 1'b0;
          state_d = WAIT;
        end
`ifdef UART_TXQ_TIMEOUT_EN
        else if (tmo_cnt_q == '0) begin
          // Byte is abandoned; tx_dat_o keeps it until the next pop.
          tx_wr_d  = 1'b0;
          tx_err_d = 1'b1;
          state_d  = IDLE;
        end else begin
          tmo_cnt_d = tmo_cnt_q - TMO_W'(1);
        end
`endif
      end
      WAIT: begin
        if (!tx_busy_i) state_d = IDLE;
      end
      default: begin
        tx_wr_d = 1'b0;
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge sys_clk_i) begin
    if (sys_rst_i) begin
      state_q  <= IDLE;
      tx_wr_q  <= 1'b0;
      tx_dat_q <= '0;
    end else begin
      state_q  <= state_d;
      tx_wr_q  <= tx_wr_d;
      tx_dat_q <= tx_dat_d;
    end
  end

`ifdef UART_TXQ_TIMEOUT_EN
  always_ff @(posedge sys_clk_i) begin
    if (sys_rst_i) begin
      tmo_cnt_q <= '0;
      tx_err_q  <= 1'b0;
    end else begin
      tmo_cnt_q <= tmo_cnt_d;
      tx_err_q  <= tx_err_d;
    end
  end

  assign tx_err_o = tx_err_q;
`else
  assign tx_err_o = 1'b0;
`endif

  assign tx_wr_o  = tx_wr_q;
  assign tx_dat_o = tx_dat_q;

endmodule

// File: tb/tb_uart_tx_queue.sv
// tb_uart_tx_queue
// Directed bench for uart_tx_queue with a simple uart busy model: once
// tx_wr_o has been seen high for m_lat negedges the model raises busy for
// m_len cycles and records the presented byte.

module tb_uart_tx_queue;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       q_wr = 1'b0;
  logic [7:0] q_dat = 8'h00;
  logic       q_flush = 1'b0;
  logic       q_full, q_empty, q_ovf;
  logic [4:0] q_level;
  logic       tx_busy = 1'b0;
  logic       tx_wr;
  logic [7:0] tx_dat;
  logic       tx_err;

  int checks = 0;
  int failures = 0;

  // uart model state (written only by the model process, except config)
  bit         m_en = 1'b0;
  int         m_lat = 3;
  int         m_len = 10;
  int         m_seen = 0;
  int         m_cnt = 0;
  int         cap_n = 0;
  logic [7:0] cap_mem [256];
  int         ovf_n = 0;
  int         err_n = 0;

  always #10 clk = ~clk;

  uart_tx_queue dut (
    .sys_clk_i (clk),
    .sys_rst_i (rst),
    .q_wr_i    (q_wr),
    .q_dat_i   (q_dat),
    .q_flush_i (q_flush),
    .q_full_o  (q_full),
    .q_empty_o (q_empty),
    .q_level_o (q_level),
    .q_ovf_o   (q_ovf),
    .tx_busy_i (tx_busy),
    .tx_wr_o   (tx_wr),
    .tx_dat_o  (tx_dat),
    .tx_err_o  (tx_err)
  );

  always @(negedge clk) begin
    if (q_ovf) ovf_n = ovf_n + 1;
    if (tx_err) err_n = err_n + 1;
    if (!m_en) begin
      tx_busy = 1'b0;
      m_seen  = 0;
      m_cnt   = 0;
    end else if (tx_busy) begin
      m_cnt = m_cnt - 1;
      if (m_cnt <= 0) tx_busy = 1'b0;
    end else if (tx_wr) begin
      m_seen = m_seen + 1;
      if (m_seen >= m_lat) begin
        tx_busy = 1'b1;
        m_cnt   = m_len;
        m_seen  = 0;
        if (cap_n < 256) cap_mem[cap_n[7:0]] = tx_dat;
        cap_n = cap_n + 1;
      end
    end else begin
      m_seen = 0;
    end
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // Waits until the uart is idle and nothing is queued or presented.
  task automatic wait_idle(input int budget, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      if (!tx_busy && !tx_wr && q_empty) begin
        ok = 1'b1;
        break;
      end
      tick();
    end
    tick();
    tick();
  endtask

  task automatic test_reset;
    rst = 1'b1;
    repeat (5) tick();
    checks++; if (tx_wr !== 1'b0) begin failures++; $display("FAIL reset_tx_wr got=%b exp=0", tx_wr); end
    checks++; if (tx_dat !== 8'h00) begin failures++; $display("FAIL reset_tx_dat got=%h exp=00", tx_dat); end
    checks++; if (q_empty !== 1'b1) begin failures++; $display("FAIL reset_empty got=%b exp=1", q_empty); end
    checks++; if (q_full !== 1'b0) begin failures++; $display("FAIL reset_full got=%b exp=0", q_full); end
    checks++; if (q_level !== 5'd0) begin failures++; $display("FAIL reset_level got=%0d exp=0", q_level); end
    checks++; if (q_ovf !== 1'b0) begin failures++; $display("FAIL reset_ovf got=%b exp=0", q_ovf); end
    checks++; if (tx_err !== 1'b0) begin failures++; $display("FAIL reset_err got=%b exp=0", tx_err); end
    repeat (14) tick();
    rst = 1'b0;
    repeat (10) tick();
  endtask

  task automatic test_single;
    int cap0, n;
    bit ok;
    m_en = 1'b1; m_lat = 3; m_len = 10;
    cap0 = cap_n;
    q_dat = 8'd27; q_wr = 1'b1;
    tick();
    q_wr = 1'b0;
    checks++; if (q_level !== 5'd1) begin failures++; $display("FAIL single_level_push got=%0d exp=1", q_level); end
    checks++; if (tx_wr !== 1'b0) begin failures++; $display("FAIL single_no_bypass got=%b exp=0", tx_wr); end
    tick();
    checks++; if (tx_wr !== 1'b1) begin failures++; $display("FAIL single_tx_wr got=%b exp=1", tx_wr); end
    checks++; if (tx_dat !== 8'd27) begin failures++; $display("FAIL single_tx_dat got=%0d exp=27", tx_dat); end
    checks++; if (q_level !== 5'd0) begin failures++; $display("FAIL single_level_pop got=%0d exp=0", q_level); end
    n = 0;
    for (int i = 0; i < 20; i++) begin
      if (!tx_wr) break;
      tick();
      n++;
    end
    checks++; if (n !== 3) begin failures++; $display("FAIL single_strobe_len got=%0d exp=3", n); end
    wait_idle(100, ok);
    checks++; if (ok !== 1'b1) begin failures++; $display("FAIL single_idle_timeout got=%b exp=1", ok); end
    checks++; if (cap_n - cap0 !== 1 || cap_mem[cap0[7:0]] !== 8'd27) begin
      failures++; $display("FAIL single_emitted got_n=%0d got=%0d exp_n=1 exp=27", cap_n - cap0, cap_mem[cap0[7:0]]);
    end
  endtask

  task automatic test_overflow;
    int cap0, ovf0, bad;
    bit ok;
    logic exp_full;
    m_en = 1'b1; m_lat = 2; m_len = 400;
    cap0 = cap_n; ovf0 = ovf_n;
    for (int j = 0; j < 18; j++) begin
      q_wr = 1'b1; q_dat = 8'(j);
      tick();
      exp_full = (j >= 16);
      checks++; if (q_full !== exp_full) begin failures++; $display("FAIL ovf_full push=%0d got=%b exp=%b", j, q_full, exp_full); end
      if (j == 17) begin
        checks++; if (q_ovf !== 1'b1) begin failures++; $display("FAIL ovf_pulse got=%b exp=1", q_ovf); end
      end
    end
    q_wr = 1'b0;
    checks++; if (q_level !== 5'd16) begin failures++; $display("FAIL ovf_level got=%0d exp=16", q_level); end
    tick();
    checks++; if (q_ovf !== 1'b0) begin failures++; $display("FAIL ovf_pulse_end got=%b exp=0", q_ovf); end
    checks++; if (ovf_n - ovf0 !== 1) begin failures++; $display("FAIL ovf_count got=%0d exp=1", ovf_n - ovf0); end
    wait_idle(17 * 450, ok);
    checks++; if (ok !== 1'b1) begin failures++; $display("FAIL ovf_drain_timeout got=%b exp=1", ok); end
    checks++; if (cap_n - cap0 !== 17) begin failures++; $display("FAIL ovf_emit_count got=%0d exp=17", cap_n - cap0); end
    bad = 0;
    for (int i = 0; i < 17; i++) begin
      if (cap_mem[8'(cap0 + i)] !== 8'(i)) bad++;
    end
    checks++; if (bad !== 0) begin failures++; $display("FAIL ovf_order wrong_bytes=%0d exp=0", bad); end
  endtask

  task automatic test_simul;
    int cap0;
    bit ok;
    m_en = 1'b1; m_lat = 2; m_len = 30;
    cap0 = cap_n;
    q_dat = 8'h1E; q_wr = 1'b1;
    tick();
    checks++; if (q_level !== 5'd1 || tx_wr !== 1'b0) begin failures++; $display("FAIL simul_setup level=%0d tx_wr=%b exp level=1 tx_wr=0", q_level, tx_wr); end
    q_dat = 8'h55;
    tick();
    q_wr = 1'b0;
    checks++; if (q_level !== 5'd1) begin failures++; $display("FAIL simul_level got=%0d exp=1", q_level); end
    checks++; if (tx_wr !== 1'b1 || tx_dat !== 8'h1E) begin failures++; $display("FAIL simul_pop tx_wr=%b tx_dat=%h exp 1/1e", tx_wr, tx_dat); end
    wait_idle(300, ok);
    checks++; if (ok !== 1'b1) begin failures++; $display("FAIL simul_idle_timeout got=%b exp=1", ok); end
    checks++; if (cap_n - cap0 !== 2 || cap_mem[cap0[7:0]] !== 8'h1E || cap_mem[8'(cap0 + 1)] !== 8'h55) begin
      failures++; $display("FAIL simul_order n=%0d b0=%h b1=%h exp n=2 1e 55", cap_n - cap0, cap_mem[cap0[7:0]], cap_mem[8'(cap0 + 1)]);
    end
  endtask

  task automatic test_flush;
    int cap0, ovf0, n;
    bit done;
    m_en = 1'b1; m_lat = 2; m_len = 300;
    cap0 = cap_n; ovf0 = ovf_n;
    q_wr = 1'b1; q_dat = 8'h1B;
    tick();
    for (int i = 1; i <= 5; i++) begin
      q_dat = 8'(i);
      tick();
    end
    q_wr = 1'b0;
    checks++; if (tx_wr !== 1'b0 || tx_busy !== 1'b1 || q_level !== 5'd5) begin
      failures++; $display("FAIL flush_setup tx_wr=%b busy=%b level=%0d exp 0/1/5", tx_wr, tx_busy, q_level);
    end
    q_flush = 1'b1; q_wr = 1'b1; q_dat = 8'h77;
    tick();
    q_flush = 1'b0; q_wr = 1'b0;
    checks++; if (q_empty !== 1'b1 || q_level !== 5'd0) begin failures++; $display("FAIL flush_empty empty=%b level=%0d exp 1/0", q_empty, q_level); end
    checks++; if (q_ovf !== 1'b0) begin failures++; $display("FAIL flush_ovf got=%b exp=0", q_ovf); end
    done = 1'b0;
    for (int i = 0; i < 400; i++) begin
      if (!tx_busy) begin done = 1'b1; break; end
      tick();
    end
    checks++; if (done !== 1'b1) begin failures++; $display("FAIL flush_busy_timeout got=%b exp=1", done); end
    n = 0;
    for (int i = 0; i < 50; i++) begin
      if (tx_wr) n++;
      tick();
    end
    checks++; if (n !== 0) begin failures++; $display("FAIL flush_no_more_wr got=%0d exp=0", n); end
    checks++; if (cap_n - cap0 !== 1 || cap_mem[cap0[7:0]] !== 8'h1B) begin
      failures++; $display("FAIL flush_completed n=%0d b0=%h exp n=1 1b", cap_n - cap0, cap_mem[cap0[7:0]]);
    end
    checks++; if (ovf_n - ovf0 !== 0) begin failures++; $display("FAIL flush_ovf_count got=%0d exp=0", ovf_n - ovf0); end
  endtask

  task automatic test_timeout;
    int err0, n;
    bit ok;
    m_en = 1'b0;
    tick();
    err0 = err_n;
    q_wr = 1'b1; q_dat = 8'h42;
    tick();
    q_dat = 8'h43;
    tick();
    q_wr = 1'b0;
`ifdef UART_TXQ_TIMEOUT_EN
    n = 0;
    for (int i = 0; i < 200; i++) begin
      if (!(tx_wr && tx_dat == 8'h42)) break;
      n++;
      tick();
    end
    checks++; if (n !== 64) begin failures++; $display("FAIL tmo_high_cycles got=%0d exp=64", n); end
    checks++; if (tx_err !== 1'b1 || tx_wr !== 1'b0) begin failures++; $display("FAIL tmo_err_pulse err=%b tx_wr=%b exp 1/0", tx_err, tx_wr); end
    tick();
    checks++; if (tx_err !== 1'b0 || tx_wr !== 1'b1 || tx_dat !== 8'h43) begin
      failures++; $display("FAIL tmo_next_byte err=%b tx_wr=%b dat=%h exp 0/1/43", tx_err, tx_wr, tx_dat);
    end
    m_en = 1'b1; m_lat = 2; m_len = 20;
    wait_idle(200, ok);
    checks++; if (ok !== 1'b1) begin failures++; $display("FAIL tmo_idle_timeout got=%b exp=1", ok); end
    checks++; if (err_n - err0 !== 1) begin failures++; $display("FAIL tmo_err_count got=%0d exp=1", err_n - err0); end
`else
    n = 0;
    for (int i = 0; i < 200; i++) begin
      if (tx_wr && tx_dat == 8'h42) n++;
      tick();
    end
    checks++; if (n !== 200) begin failures++; $display("FAIL notmo_hold got=%0d exp=200", n); end
    m_en = 1'b1; m_lat = 2; m_len = 20;
    wait_idle(200, ok);
    checks++; if (ok !== 1'b1) begin failures++; $display("FAIL notmo_idle_timeout got=%b exp=1", ok); end
    checks++; if (err_n - err0 !== 0) begin failures++; $display("FAIL notmo_err_count got=%0d exp=0", err_n - err0); end
`endif
  endtask

  task automatic test_reset_mid;
    int n;
    m_en = 1'b0;
    tick();
    q_wr = 1'b1;
    q_dat = 8'hA1; tick();
    q_dat = 8'hA2; tick();
    q_dat = 8'hA3; tick();
    q_wr = 1'b0;
    tick();
    checks++; if (tx_wr !== 1'b1 || tx_dat !== 8'hA1) begin failures++; $display("FAIL rstmid_setup tx_wr=%b dat=%h exp 1/a1", tx_wr, tx_dat); end
    rst = 1'b1;
    tick();
    checks++; if (tx_wr !== 1'b0 || tx_dat !== 8'h00) begin failures++; $display("FAIL rstmid_tx tx_wr=%b dat=%h exp 0/00", tx_wr, tx_dat); end
    checks++; if (q_empty !== 1'b1 || q_full !== 1'b0 || q_level !== 5'd0) begin
      failures++; $display("FAIL rstmid_flags empty=%b full=%b level=%0d exp 1/0/0", q_empty, q_full, q_level);
    end
    checks++; if (q_ovf !== 1'b0 || tx_err !== 1'b0) begin failures++; $display("FAIL rstmid_pulses ovf=%b err=%b exp 0/0", q_ovf, tx_err); end
    rst = 1'b0;
    n = 0;
    for (int i = 0; i < 10; i++) begin
      tick();
      if (tx_wr) n++;
    end
    checks++; if (n !== 0 || q_empty !== 1'b1) begin failures++; $display("FAIL rstmid_lost wr_cycles=%0d empty=%b exp 0/1", n, q_empty); end
  endtask

  initial begin
    test_reset();
    test_single();
    test_overflow();
    test_simul();
    test_flush();
    test_timeout();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog expired checks=%0d failures=%0d", checks, failures);
    $fatal(1, "watchdog");
  end

endmodule
